seg_scan_decoder: RTL
=====================

# seg_scan_decoder

Readback receiver for the multiplexed 7-segment display bus. Monitors the active-low `Segments`/`Digit_En` scan produced by the display driver and reconstructs the displayed value. Decodes each settled digit, assembles one ones/tens/hundreds frame and converts BCD to binary. Reports the result with a one-cycle `Valid` pulse. Used as an on-chip self-check of the display path and as a bench monitor.

## Interface
- `SETTLE_CYCLES`, 16: consecutive identical samples needed before a digit phase is accepted (range 2..65535).
- `clk` in 1: 100 MHz system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `Segments` in 8: bits 6:0 are segments G..A, active-low; bit 7 is the decimal point and is ignored.
- `Digit_En` in 4: active-low digit select.
  - `1110`: ones.
  - `1101`: tens.
  - `1011`: hundreds.
  - `1111`: blank, marks end of frame.
- `Number` out 8: last good value, saturated at 255.
- `Overflow` out 1: last good frame decoded above 255; updated together with `Number`.
- `Valid` out 1: one-cycle pulse when `Number`/`Overflow` update.
- `Pattern_Err` out 1: one-cycle pulse on an illegal settled segment code or `Digit_En` code.
- `Frame_Err` out 1: one-cycle pulse when a frame ends incomplete or corrupted.

## Operation
- **Input register.** `Segments` and `Digit_En` are registered once into `s_seg` and `s_en`. All logic uses the registered pair.
- **Settle counter.**
  - Clears whenever `{s_en, s_seg}` differs from the previous cycle; otherwise increments, saturating at `SETTLE_CYCLES`.
  - A phase *qualifies* on the cycle the counter reaches `SETTLE_CYCLES-1`. It qualifies once per phase.
- **Pattern decode** (bits 6:0 → digit):
  - `1000000`=0, `1111001`=1, `0100100`=2, `0110000`=3, `0011001`=4.
  - `0010010`=5, `0000010`=6, `1111000`=7, `0000000`=8, `0010000`=9.
  - Any other code is illegal.
- **State machine** (enum `SYNC`, `SCAN`, `CONV`, `REPORT`; reset state `SYNC`):
  - `SYNC`: ignore everything until a blank phase qualifies, then go to `SCAN` with captures cleared. Errors are not reported in `SYNC`.
  - `SCAN`, digit phase qualifies: store the decoded digit in its slot and set that slot's captured flag. A repeated slot overwrites the previous value.
  - `SCAN`, illegal segment code or illegal `Digit_En` qualifies: pulse `Pattern_Err` and set `bad`.
  - `SCAN`, blank qualifies:
    - all three flags set and `bad`=0: go to `CONV`;
    - otherwise: pulse `Frame_Err`, clear flags and `bad`, stay in `SCAN`.
  - `CONV` (1 cycle): `acc` (10 bits) = H*100 + T*10 + O, computed as (H<<6)+(H<<5)+(H<<2)+(T<<3)+(T<<1)+O.
  - `REPORT` (1 cycle): `Number` = `acc` > 255 ? 255 : `acc[7:0]`; `Overflow` = (`acc` > 255); `Valid` = 1. Clear flags and `bad`, return to `SCAN`.
- **Input changes during `CONV`/`REPORT`.** The settle counter keeps running. A phase that qualifies in these states is processed after return to `SCAN` only if it is still the current phase: the counter does not re-trigger on the same phase, so a qualification landing in `CONV`/`REPORT` is lost. Because `SETTLE_CYCLES` ≥ 2 and every display phase lasts far longer than 2 cycles, no real phase qualifies there.

## Timing
- **Reset values.** All outputs 0. State `SYNC`, counter 0, flags, `bad`, slots and `acc` cleared. An `rst_n` assertion mid-frame discards the frame immediately, with no error pulse.
- **Qualification latency.** A stable input change at pin edge k qualifies at cycle k+1+(`SETTLE_CYCLES`-1).
- **Result latency.**
  - Blank qualifies in cycle N.
  - `CONV` is cycle N+1.
  - `Valid` is high in cycle N+2 only, with `Number`/`Overflow` updated on the same edge and held afterwards.
- **Error pulse timing.** `Pattern_Err` and `Frame_Err` are high in the cycle after their qualifying event. They can coincide only across different frames, never in the same cycle.
- **Glitch rejection.** Glitches shorter than `SETTLE_CYCLES` samples are invisible.
- **Minimum phase length.** A phase must last at least `SETTLE_CYCLES`+1 cycles; the driver's ~1.3 ms phases satisfy this for any legal parameter value.

## Structure
- Package `seg_pkg` holds:
  - the ten segment-code constants;
  - the `Digit_En` codes (`EN_ONES`, `EN_TENS`, `EN_HUND`, `EN_BLANK`);
  - the state enum typedef.
- Sub-module `seg_pattern_decoder`: combinational 7-bit code → {4-bit digit, illegal flag}.
- Everything else stays in `seg_scan_decoder`.

## Test plan
- **Nominal frame.** Bench model scans 1/7/3 (hundreds/tens/ones), `SETTLE_CYCLES`=4, 20-cycle phases → after the first blank for alignment, then one full frame, `Valid` pulses once with `Number`=173, `Overflow`=0.
- **Boundaries.** Frames for 000, 255 and 999 → `Number`=0/`Overflow`=0; `Number`=255/`Overflow`=0; `Number`=255/`Overflow`=1.
- **Illegal segment code.** Tens phase drives `Segments`=`0xFF` → one `Pattern_Err` pulse, `Frame_Err` at the blank, no `Valid`, `Number` holds its previous value.
- **Glitch rejection.** 2-cycle glitch (`SETTLE_CYCLES`=4) to code 8 inside the ones phase of 173 → `Valid` with `Number`=173, no error pulses.
- **Missing digit.** Frame omits the hundreds phase → `Frame_Err` pulse at the blank, no `Valid`; the next good frame reports normally.
- **Reset mid-frame.** `rst_n` low during the tens phase → all outputs 0 immediately; no pulses until a blank re-aligns; the first full frame afterwards gives `Valid`.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants and types for the 7-segment scan readback receiver.
// Segment codes are bits G..A, active-low; Digit_En codes are active-low digit selects.
package seg_pkg;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;

    localparam logic [3:0] EN_ONES  = 4'b1110;
    localparam logic [3:0] EN_TENS  = 4'b1101;
    localparam logic [3:0] EN_HUND  = 4'b1011;
    localparam logic [3:0] EN_BLANK = 4'b1111;

    typedef enum logic [1:0] {
        SYNC,
        SCAN,
        CONV,
        REPORT
    } state_t;

endpackage

// File: rtl/seg_pattern_decoder.sv
// Combinational 7-segment code to BCD digit decoder with an illegal-code flag.
module seg_pattern_decoder
    import seg_pkg::*;
(
    input  logic [6:0] code,
    output logic [3:0] digit,
    output logic       illegal
);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        digit   = 4'd0;
        illegal = 1'b0;
        case (code)
            SEG_0:   digit = 4'd0;
            SEG_1:   digit = 4'd1;
            SEG_2:   digit = 4'd2;
            SEG_3:   digit = 4'd3;
            SEG_4:   digit = 4'd4;
            SEG_5:   digit = 4'd5;
            SEG_6:   digit = 4'd6;
            SEG_7:   digit = 4'd7;
            SEG_8:   digit = 4'd8;
            SEG_9:   digit = 4'd9;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Readback receiver for the multiplexed 7-segment bus: settles each phase, assembles
// a hundreds/tens/ones frame and reports the binary value with a one-cycle Valid pulse.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] Segments,
    input  logic [3:0] Digit_En,
    output logic [7:0] Number,
    output logic       Overflow,
    output logic       Valid,
    output logic       Pattern_Err,
    output logic       Frame_Err
);

    localparam int unsigned CW = 16;
    localparam logic [CW-1:0] SETTLE_MAX = CW'(SETTLE_CYCLES);
    localparam logic [CW-1:0] QUAL_AT    = CW'(SETTLE_CYCLES - 1);

    logic [6:0]    s_seg;
    logic [3:0]    s_en;
    logic [10:0]   prev_key;
    logic [CW-1:0] cnt;
    logic          qualify;

    logic unused_dp;
    assign unused_dp = Segments[7];

    // The decimal point is dropped at the input so it never restarts the settle count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_seg    <= '0;
            s_en     <= '0;
            prev_key <= '0;
            cnt      <= '0;
        end else begin
            // NOTE: non-blocking assignments make every register sample pre-edge values.
            s_seg    <= Segments[6:0];
            s_en     <= Digit_En;
            prev_key <= {s_en, s_seg};
            if ({s_en, s_seg} != prev_key)
                cnt <= '0;
            else if (cnt != SETTLE_MAX)
                cnt <= cnt + 1'b1;
        end
    end

    assign qualify = (cnt == QUAL_AT) && ({s_en, s_seg} == prev_key);

    logic [3:0] dec_digit;
    logic       dec_illegal;

    seg_pattern_decoder u_dec (
        .code    (s_seg),
        .digit   (dec_digit),
        .illegal (dec_illegal)
    );

    state_t     state;
    logic [3:0] ones, tens, hund;
    logic [2:0] flags;
    logic       bad;
    logic [9:0] acc;
    logic [9:0] acc_sum;
    logic       en_digit;

    assign en_digit = (s_en == EN_ONES) || (s_en == EN_TENS) || (s_en == EN_HUND);

    // H*100 + T*10 + O using shifts only.
    assign acc_sum = (10'(hund) << 6) + (10'(hund) << 5) + (10'(hund) << 2)
                   + (10'(tens) << 3) + (10'(tens) << 1) + 10'(ones);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= SYNC;
            ones        <= '0;
            tens        <= '0;
            hund        <= '0;
            flags       <= '0;
            bad         <= 1'b0;
            acc         <= '0;
            Number      <= '0;
            Overflow    <= 1'b0;
            Valid       <= 1'b0;
            Pattern_Err <= 1'b0;
            Frame_Err   <= 1'b0;
        end else begin
            Valid       <= 1'b0;
            Pattern_Err <= 1'b0;
            Frame_Err   <= 1'b0;
            case (state)
                SYNC: begin
                    if (qualify && s_en == EN_BLANK) begin
                        state <= SCAN;
                        flags <= '0;
                        bad   <= 1'b0;
                    end
                end
                SCAN: begin
                    if (qualify) begin
                        if (s_en == EN_BLANK) begin
                            if (&flags && !bad) begin
                                state <= CONV;
                            end else begin
                                Frame_Err <= 1'b1;
                                flags     <= '0;
                                bad       <= 1'b0;
                            end
                        end else if (en_digit && !dec_illegal) begin
                            case (s_en)
                                EN_ONES: begin ones <= dec_digit; flags[0] <= 1'b1; end
                                EN_TENS: begin tens <= dec_digit; flags[1] <= 1'b1; end
                                default: begin hund <= dec_digit; flags[2] <= 1'b1; end
                            endcase
                        end else begin
                            Pattern_Err <= 1'b1;
                            bad         <= 1'b1;
                        end
                    end
                end
                CONV: begin
                    acc   <= acc_sum;
                    state <= REPORT;
                    // Outputs load on the REPORT entry edge so Valid is visible during REPORT.
                    Number   <= (acc_sum > 10'd255) ? 8'hFF : acc_sum[7:0];
                    Overflow <= (acc_sum > 10'd255);
                    Valid    <= 1'b1;
                end
                REPORT: begin
                    flags <= '0;
                    bad   <= 1'b0;
                    state <= SCAN;
                end
                default: state <= SYNC;
            endcase
        end
    end

endmodule
